aes_block_assembler: RTL and testbench



---
 rtl/aes_block_assembler.sv | 124 ++++++++++++
 tb/tb_aes_block_assembler.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/aes_block_assembler.sv
// Packs 16 received bytes into one 128-bit AES block, first byte in the top lane.
// Define AES_ASM_TIMEOUT_EN to discard partial blocks after TIMEOUT_CYCLES idle cycles.
module aes_block_assembler #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   s_data,
  input  logic         s_valid,
  output logic         s_ready,
  output logic [127:0] m_block,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [4:0]   byte_cnt,
  output logic         err_timeout
);

  localparam logic [4:0] CntLast = 5'd15;
  localparam logic [4:0] CntFull = 5'd16;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : gen_bad_timeout
    $error("TIMEOUT_CYCLES must be within 1..65535");
  end

  logic [4:0]   cnt_q, cnt_d;
  // Full 128 bits so a 16th byte can park here while the output slot is busy.
  logic [127:0] acc_q, acc_d;
  logic [127:0] m_block_q, m_block_d;
  logic         m_valid_q, m_valid_d;
  logic         accept, slot_free, expire;

  assign s_ready   = rst_n && (cnt_q < CntFull);
  assign accept    = s_valid && s_ready;
  assign slot_free = !m_valid_q || m_ready;

`ifdef AES_ASM_TIMEOUT_EN
  localparam logic [15:0] TimeoutMax = 16'(TIMEOUT_CYCLES);

  logic [15:0] idle_q, idle_d;
  logic        err_q;

  always_comb begin
    idle_d = '0;
    expire = 1'b0;
    if (!accept && cnt_q != '0 && cnt_q != CntFull) begin
      if (idle_q + 16'd1 == TimeoutMax) begin
        expire = 1'b1;
      end else begin
        idle_d = idle_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idle_q <= '0;
      err_q  <= 1'b0;
    end else begin
      idle_q <= idle_d;
      err_q  <= expire;
    end
  end

  assign err_timeout = err_q;
`else
  assign expire      = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_comb begin
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    m_block_d = m_block_q;
    m_valid_d = m_valid_q;

    if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
    end

    if (accept) begin
      acc_d = {acc_q[119:0], s_data};
      if (cnt_q == CntLast) begin
        if (slot_free) begin
          m_block_d = {acc_q[119:0], s_data};
          m_valid_d = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = CntFull;
        end
      end else begin
        cnt_d = cnt_q + 5'd1;
      end
    end else if (cnt_q == CntFull && slot_free) begin
      m_block_d = acc_q;
      m_valid_d = 1'b1;
      cnt_d     = '0;
    end

    // Expiry only fires on an idle partial block, so it never races a load.
    if (expire) begin
      cnt_d = '0;
      acc_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      m_block_q <= '0;
      m_valid_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      m_block_q <= m_block_d;
      m_valid_q <= m_valid_d;
    end
  end

  assign m_block  = m_block_q;
  assign m_valid  = m_valid_q;
  assign byte_cnt = cnt_q;

endmodule

// File: tb/tb_aes_block_assembler.sv
// Randomised bench for aes_block_assembler against a byte-queue reference model.
// Build with AES_ASM_TIMEOUT_EN defined to also exercise the inactivity timeout.
module tb_aes_block_assembler;

  localparam int unsigned TimeoutCycles = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   s_data;
  logic         s_valid;
  logic         s_ready;
  logic [127:0] m_block;
  logic         m_valid;
  logic         m_ready;
  logic [4:0]   byte_cnt;
  logic         err_timeout;

  aes_block_assembler #(
    .TIMEOUT_CYCLES(TimeoutCycles)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .m_block    (m_block),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .byte_cnt   (byte_cnt),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Reference model: bytes waiting in the accumulator plus the output slot.
  logic [7:0]   mq[$];
  logic         mv;
  logic [127:0] mb;
  logic         merr;
  int           midle;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mv    = 1'b0;
    mb    = '0;
    merr  = 1'b0;
    midle = 0;
  endtask

  // Drive one clock cycle: apply inputs, compare outputs, advance the model.
  task automatic cycle(input logic rst, input logic v, input logic [7:0] d, input logic mr,
                       output logic accepted);
    logic         rdy, slot;
    int           sz0;
    logic [127:0] blk;
    @(negedge clk);
    rst_n   = rst;
    s_valid = v;
    s_data  = d;
    m_ready = mr;
    #1;
    rdy = rst && (mq.size() < 16);
    check("s_ready", 128'(s_ready), 128'(rdy));
    check("byte_cnt", 128'(byte_cnt), 128'(mq.size()));
    check("m_valid", 128'(m_valid), 128'(mv));
    check("m_block", m_block, mb);
    check("err_timeout", 128'(err_timeout), 128'(merr));
    accepted = v && rdy;
    if (!rst) begin
      model_reset();
    end else begin
      sz0  = mq.size();
      slot = !mv || mr;
      merr = 1'b0;
      if (mv && mr) mv = 1'b0;
      if (accepted) mq.push_back(d);
      if (mq.size() == 16 && slot) begin
        blk = '0;
        foreach (mq[i]) blk = {blk[119:0], mq[i]};
        mb = blk;
        mv = 1'b1;
        mq.delete();
      end
`ifdef AES_ASM_TIMEOUT_EN
      if (!accepted && sz0 > 0 && sz0 < 16) begin
        midle++;
        if (midle == int'(TimeoutCycles)) begin
          mq.delete();
          merr  = 1'b1;
          midle = 0;
        end
      end else begin
        midle = 0;
      end
`else
      if (sz0 < 0) midle = 0;
`endif
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic mr);
    logic acc;
    for (int t = 0; t < 40; t++) begin
      cycle(1'b1, 1'b1, d, mr, acc);
      if (acc) return;
    end
    check("send_budget", 128'(0), 128'(1));
  endtask

  task automatic idle(input int n, input logic mr);
    logic acc;
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 8'h00, mr, acc);
  endtask

  logic [7:0]   vec[16] = '{8'h69, 8'hc4, 8'he0, 8'hd8, 8'h6a, 8'h7b, 8'h04, 8'h30,
                            8'hd8, 8'hcd, 8'hb7, 8'h80, 8'h70, 8'hb4, 8'hc5, 8'h5a};
  logic [127:0] blk1, blk2;
  logic [7:0]   b;
  logic         acc;

  initial begin
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();
    cycle(1'b0, 1'b0, 8'h00, 1'b0, acc);
    idle(1, 1'b1);

    // Known-answer single block.
    foreach (vec[i]) send_byte(vec[i], 1'b1);
    idle(1, 1'b1);
    check("kat_block", m_block, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    check("kat_valid", 128'(m_valid), 128'(1));
    idle(2, 1'b1);

    // Three back-to-back blocks.
    for (int i = 0; i < 48; i++) send_byte(8'($urandom), 1'b1);
    idle(2, 1'b1);

    // Backpressure into HOLD, then one-cycle release.
    blk1 = '0;
    blk2 = '0;
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom);
      blk1 = {blk1[119:0], b};
      send_byte(b, 1'b0);
    end
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom);
      blk2 = {blk2[119:0], b};
      send_byte(b, 1'b0);
    end
    idle(2, 1'b0);
    check("hold_cnt", 128'(byte_cnt), 128'(16));
    check("hold_ready", 128'(s_ready), 128'(0));
    check("hold_blk1", m_block, blk1);
    idle(1, 1'b1);
    idle(1, 1'b0);
    check("release_blk2", m_block, blk2);
    check("release_valid", 128'(m_valid), 128'(1));
    idle(1, 1'b0);
    check("release_ready", 128'(s_ready), 128'(1));
    idle(2, 1'b1);

    // 16th byte of block 2 meets m_ready while block 1 is pending.
    for (int i = 0; i < 16; i++) send_byte(8'($urandom), 1'b0);
    blk2 = '0;
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom);
      blk2 = {blk2[119:0], b};
      send_byte(b, (i == 15));
    end
    idle(1, 1'b0);
    check("simul_blk2", m_block, blk2);
    check("simul_valid", 128'(m_valid), 128'(1));
    check("simul_cnt", 128'(byte_cnt), 128'(0));
    idle(2, 1'b1);

    // Reset mid-block, then a clean block.
    for (int i = 0; i < 7; i++) send_byte(8'($urandom), 1'b1);
    cycle(1'b0, 1'b0, 8'h00, 1'b1, acc);
    idle(1, 1'b1);
    check("rst_cnt", 128'(byte_cnt), 128'(0));
    check("rst_valid", 128'(m_valid), 128'(0));
    check("rst_err", 128'(err_timeout), 128'(0));
    for (int i = 0; i < 16; i++) send_byte(8'($urandom), 1'b1);
    idle(2, 1'b1);

`ifdef AES_ASM_TIMEOUT_EN
    // Stale partial block expires after TimeoutCycles idle cycles.
    for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1'b1);
    idle(int'(TimeoutCycles), 1'b1);
    idle(1, 1'b1);
    check("to_err", 128'(err_timeout), 128'(1));
    check("to_cnt", 128'(byte_cnt), 128'(0));
    idle(1, 1'b1);
    for (int i = 0; i < 16; i++) send_byte(8'($urandom), 1'b1);
    idle(2, 1'b1);
`endif

    // Random traffic with random backpressure.
    for (int i = 0; i < 600; i++) begin
      cycle(1'b1, ($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 2) != 0), acc);
    end
    idle(3, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
